uart_rx: RTL



---
 rtl/uart_rx_pkg.sv | 17 +
 rtl/uart_rx_sync_2ff.sv | 30 +++
 rtl/uart_rx.sv | 113 +++++++++++
 3 files changed

// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receiver: FSM state encoding, oversampling
// constants and counter widths.
package uart_rx_pkg;

  localparam int unsigned OVS      = 16;  // s_ticks per bit
  localparam int unsigned MID_TICK = 7;   // tick index of the mid-start-bit check
  localparam int unsigned S_W      = 5;   // tick counter width (stop period up to 32)
  localparam int unsigned N_W      = 3;   // data bit counter width

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    DATA  = 2'b10,
    STOP  = 2'b11
  } rx_state_e;

endpackage

// File: rtl/uart_rx_sync_2ff.sv
// Two-flop synchronizer for an asynchronous single-bit input.
// Ports:
//   clk, rst_n : clock, async active-low reset (flops load RST_VAL)
//   d_i        : asynchronous input
//   q_o        : synchronized output, 2 clk latency
module uart_rx_sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receive sequencer. Oversamples the serial line at 16x baud (s_tick),
// confirms the start bit at mid-bit, samples DBIT data bits LSB first at
// mid-bit, checks the stop level and presents the word with a 1-clk strobe.
// Ports:
//   clk, rst_n   : clock, async active-low reset
//   rx           : serial line, asynchronous, idle high
//   s_tick       : 1-clk pulse at 16x baud
//   dout         : last received word (held until next completion)
//   rx_done_tick : 1-clk pulse one clk after the final stop tick
//   frame_err    : stop level was low on the last completed frame
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int unsigned DBIT    = 8,
  parameter int unsigned SB_TICK = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            rx,
  input  logic            s_tick,
  output logic [DBIT-1:0] dout,
  output logic            rx_done_tick,
  output logic            frame_err
);

  rx_state_e       state_q;
  logic [S_W-1:0]  s_q;
  logic [N_W-1:0]  n_q;
  logic [DBIT-1:0] b_q;
  logic [DBIT-1:0] dout_q;
  logic            done_q;
  logic            ferr_q;
  logic            rx_s;

  uart_rx_sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (rx),
    .q_o   (rx_s)
  );

  // Receive sequencer; only the IDLE exit ignores s_tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      dout_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!rx_s) begin
            state_q <= START;
            s_q     <= '0;
          end
        end
        START: begin
          if (s_tick) begin
            if (s_q == S_W'(MID_TICK)) begin
              // Line must still be low at mid-start-bit, else it was a glitch.
              if (!rx_s) begin
                state_q <= DATA;
                s_q     <= '0;
                n_q     <= '0;
              end else begin
                state_q <= IDLE;
              end
            end else begin
              s_q <= s_q + S_W'(1);
            end
          end
        end
        DATA: begin
          if (s_tick) begin
            if (s_q == S_W'(OVS - 1)) begin
              s_q <= '0;
              b_q <= {rx_s, b_q[DBIT-1:1]};
              if (n_q == N_W'(DBIT - 1)) begin
                state_q <= STOP;
              end else begin
                n_q <= n_q + N_W'(1);
              end
            end else begin
              s_q <= s_q + S_W'(1);
            end
          end
        end
        STOP: begin
          if (s_tick) begin
            if (s_q == S_W'(SB_TICK - 1)) begin
              state_q <= IDLE;
              dout_q  <= b_q;
              ferr_q  <= ~rx_s;
              done_q  <= 1'b1;
            end else begin
              s_q <= s_q + S_W'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dout         = dout_q;
  assign rx_done_tick = done_q;
  assign frame_err    = ferr_q;

endmodule
